// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    // One-cold column strobes, same pattern as the display digit enables
    localparam logic [3:0] COL_PAT_0 = 4'b0111;
    localparam logic [3:0] COL_PAT_1 = 4'b1011;
    localparam logic [3:0] COL_PAT_2 = 4'b1101;
    localparam logic [3:0] COL_PAT_3 = 4'b1110;

    function automatic logic [3:0] col_pat(input logic [1:0] idx);
        logic [3:0] pat;
        case (idx)
            2'd0:    pat = COL_PAT_0;
            2'd1:    pat = COL_PAT_1;
            2'd2:    pat = COL_PAT_2;
            default: pat = COL_PAT_3;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Pin-side and consumer-side signals of the keypad scanner, plus FSM state for observation.
interface keypad_scan_if;
    import keypad_pkg::*;

    // key_valid is a one-cycle strobe with no back-pressure (no ready);
    // key_code is stable from that cycle until the next acceptance.
    logic [3:0]       row_in;
    logic [3:0]       col_out;
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_pressed;
    state_e           state;

    modport master (
        input  row_in,
        output col_out, key_code, key_valid, key_pressed, state
    );

    modport slave (
        output row_in,
        input  col_out, key_code, key_valid, key_pressed, state
    );

endinterface

// File: rtl/keypad_scan_sync_2ff.sv
// Reset-less two-flop synchronizer for the asynchronous keypad row lines.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        r_meta <= i_d;
        r_sync <= r_meta;
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan.sv
// Column-strobed 4x4 keypad scanner with press/release debounce and single-key rollover.
// Optional auto-repeat while held is enabled by defining KEYPAD_TYPEMATIC_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 250
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.master kp
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_SCANS);

    logic [3:0]       w_row_s;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    state_e           r_state, w_state_n;
    logic [1:0]       r_col_idx, w_col_idx_n;
    logic [1:0]       r_cand_row, w_cand_row_n;
    logic [3:0]       r_cnt, w_cnt_n;
    logic [KEY_W-1:0] r_key_code, w_key_code_n;
    logic             r_key_valid, w_key_valid_n;
    logic             r_key_pressed, w_key_pressed_n;
    logic             w_hit;
    logic [1:0]       w_hit_row;
    logic             w_cand_low;
    logic [3:0]       w_cnt_inc;

`ifdef KEYPAD_TYPEMATIC_EN
    localparam int               REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_N = REP_W'(REPEAT_SCANS);
    logic [REP_W-1:0] r_rep, w_rep_n, w_rep_inc;
    assign w_rep_inc = r_rep + REP_W'(1);
`endif

    sync_2ff #(.W(4)) u_sync (
        .clk (clk),
        .i_d (kp.row_in),
        .o_q (w_row_s)
    );

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)      r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + DIV_W'(1);
    end

    // Row 0 wins when several rows are low in the strobed column
    always_comb begin
        w_hit_row = 2'd3;
        if      (!w_row_s[0]) w_hit_row = 2'd0;
        else if (!w_row_s[1]) w_hit_row = 2'd1;
        else if (!w_row_s[2]) w_hit_row = 2'd2;
    end

    assign w_hit      = ~&w_row_s;
    assign w_cand_low = ~w_row_s[r_cand_row];
    assign w_cnt_inc  = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

    always_comb begin
        w_state_n       = r_state;
        w_col_idx_n     = r_col_idx;
        w_cand_row_n    = r_cand_row;
        w_cnt_n         = r_cnt;
        w_key_code_n    = r_key_code;
        w_key_valid_n   = 1'b0;
        w_key_pressed_n = r_key_pressed;
`ifdef KEYPAD_TYPEMATIC_EN
        w_rep_n         = r_rep;
`endif
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_hit) begin
                        w_cand_row_n = w_hit_row;
                        w_cnt_n      = 4'd1;
                        if (DEB_N == 4'd1) begin
                            w_key_code_n    = {w_hit_row, r_col_idx};
                            w_key_valid_n   = 1'b1;
                            w_key_pressed_n = 1'b1;
                            w_state_n       = HELD;
`ifdef KEYPAD_TYPEMATIC_EN
                            w_rep_n         = '0;
`endif
                        end else begin
                            w_state_n = DEBOUNCE;
                        end
                    end else begin
                        w_col_idx_n = r_col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_cand_low) begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc == DEB_N) begin
                            w_key_code_n    = {r_cand_row, r_col_idx};
                            w_key_valid_n   = 1'b1;
                            w_key_pressed_n = 1'b1;
                            w_state_n       = HELD;
`ifdef KEYPAD_TYPEMATIC_EN
                            w_rep_n         = '0;
`endif
                        end
                    end else begin
                        w_state_n   = SCAN;
                        w_col_idx_n = r_col_idx + 2'd1;
                    end
                end
                HELD: begin
                    if (!w_cand_low) begin
                        w_cnt_n   = 4'd1;
                        w_state_n = RELEASE;
                    end
`ifdef KEYPAD_TYPEMATIC_EN
                    else if (w_rep_inc == REP_N) begin
                        w_key_valid_n = 1'b1;
                        w_rep_n       = '0;
                    end else begin
                        w_rep_n = w_rep_inc;
                    end
`endif
                end
                RELEASE: begin
                    if (!w_cand_low) begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc == DEB_N) begin
                            w_key_pressed_n = 1'b0;
                            w_state_n       = SCAN;
                            w_col_idx_n     = r_col_idx + 2'd1;
                        end
                    end else begin
                        w_state_n = HELD;
`ifdef KEYPAD_TYPEMATIC_EN
                        w_rep_n   = '0;
`endif
                    end
                end
                default: w_state_n = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= SCAN;
            r_col_idx     <= 2'd0;
            r_cand_row    <= 2'd0;
            r_cnt         <= 4'd0;
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_pressed <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
            r_rep         <= '0;
`endif
        end else begin
            r_state       <= w_state_n;
            r_col_idx     <= w_col_idx_n;
            r_cand_row    <= w_cand_row_n;
            r_cnt         <= w_cnt_n;
            r_key_code    <= w_key_code_n;
            r_key_valid   <= w_key_valid_n;
            r_key_pressed <= w_key_pressed_n;
`ifdef KEYPAD_TYPEMATIC_EN
            r_rep         <= w_rep_n;
`endif
        end
    end

    assign kp.col_out     = col_pat(r_col_idx);
    assign kp.key_code    = r_key_code;
    assign kp.key_valid   = r_key_valid;
    assign kp.key_pressed = r_key_pressed;
    assign kp.state       = r_state;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed and randomized checks of keypad_scan against a tick-level keypad model.
module tb_keypad_scan;
    import keypad_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int REP      = 5;
`ifdef KEYPAD_TYPEMATIC_EN
    localparam bit TYPEMATIC = 1'b1;
`else
    localparam bit TYPEMATIC = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_scan_if kif ();

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_SCANS   (REP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kif)
    );

    // Physical matrix: key bit r*4+c pulls row r low while column c is strobed (col_out[3-c] low)
    logic [15:0] keys = '0;
    logic [3:0]  row_drive;
    always_comb begin
        row_drive = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (kif.col_out[3-c] == 1'b0)) row_drive[r] = 1'b0;
    end
    assign kif.row_in = row_drive;

    int checks   = 0;
    int failures = 0;
    int n_pulses = 0;

    logic [3:0] exp_q[$];
    logic [3:0] hist[$];

    int         m_div = 0, m_col = 0, m_row = 0, m_run = 0, m_rep = 0;
    bit         m_busy = 0, m_holding = 0, m_releasing = 0;
    logic [3:0] m_code = '0;
    logic       m_pulse = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_div = 0; m_col = 0; m_row = 0; m_run = 0; m_rep = 0;
        m_busy = 0; m_holding = 0; m_releasing = 0;
        m_code = '0;
        exp_q.delete();
    endtask

    task automatic model_accept();
        m_code    = 4'(m_row * 4 + m_col);
        m_holding = 1;
        m_rep     = 0;
        m_pulse   = 1'b1;
        exp_q.push_back(m_code);
    endtask

    // One scan instant: s is the row vector the scanner sees at this tick
    task automatic model_tick(input logic [3:0] s);
        bit cand_low;
        if (!m_busy) begin
            if (s != 4'hF) begin
                for (int r = 3; r >= 0; r--) if (!s[r]) m_row = r;
                m_run  = 1;
                m_busy = 1;
                if (m_run == DEB) model_accept();
            end else begin
                m_col = (m_col + 1) % 4;
            end
        end else begin
            cand_low = !s[m_row];
            if (!m_holding) begin
                if (cand_low) begin
                    m_run = (m_run < 15) ? m_run + 1 : 15;
                    if (m_run == DEB) model_accept();
                end else begin
                    m_busy = 0;
                    m_col  = (m_col + 1) % 4;
                end
            end else if (!m_releasing) begin
                if (!cand_low) begin
                    m_run       = 1;
                    m_releasing = 1;
                end else if (TYPEMATIC) begin
                    m_rep++;
                    if (m_rep == REP) begin
                        m_rep   = 0;
                        m_pulse = 1'b1;
                        exp_q.push_back(m_code);
                    end
                end
            end else begin
                if (!cand_low) begin
                    m_run = (m_run < 15) ? m_run + 1 : 15;
                    if (m_run == DEB) begin
                        m_holding   = 0;
                        m_releasing = 0;
                        m_busy      = 0;
                        m_col       = (m_col + 1) % 4;
                    end
                end else begin
                    m_releasing = 0;
                    m_rep       = 0;
                end
            end
        end
    endtask

    // Advance one clock, update the model, then compare every output
    task automatic step();
        logic [3:0] pre, s;
        logic [3:0] exp_code;
        bit tick;
        #1;
        pre = kif.row_in;
        @(posedge clk);
        s = (hist.size() >= 2) ? hist[0] : 4'hF;
        hist.push_back(pre);
        if (hist.size() > 2) void'(hist.pop_front());
        m_pulse = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            tick  = (m_div == SCAN_DIV - 1);
            m_div = (m_div + 1) % SCAN_DIV;
            if (tick) model_tick(s);
        end
        #1;
        check("col_out", kif.col_out, 4'hF ^ (4'h8 >> m_col));
        check("key_valid", kif.key_valid, m_pulse);
        check("key_pressed", kif.key_pressed, m_holding);
        check("key_code", kif.key_code, m_code);
        if (kif.key_valid === 1'b1) begin
            n_pulses++;
            check("sb_expected_strobe", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_code = exp_q.pop_front();
                check("sb_code", kif.key_code, exp_code);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input int budget, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (kif.key_valid === 1'b1) seen = 1;
        end
        check(tag, seen, 1);
    endtask

    task automatic wait_released(input int budget, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (kif.key_pressed === 1'b0) seen = 1;
        end
        check(tag, seen, 1);
    endtask

    initial begin
        bit dropped;
        int k;

        model_reset();
        run(3);
        check("rst_col_out", kif.col_out, 4'b0111);
        check("rst_key_valid", kif.key_valid, 0);
        check("rst_key_pressed", kif.key_pressed, 0);
        check("rst_key_code", kif.key_code, 4'h0);
        rst_n = 1'b1;
        run(17);

        // Row 2 / column 1
        keys[2*4+1] = 1'b1;
        n_pulses = 0;
        wait_valid(60, "press_strobe_timeout");
        check("press_code", kif.key_code, 4'b1001);
        run(20);
        check("press_single_pulse", n_pulses, 1);
        check("press_col_frozen", kif.col_out, 4'b1011);
        check("press_held", kif.key_pressed, 1);

        keys = '0;
        wait_released(40, "release_timeout");
        check("release_code_kept", kif.key_code, 4'b1001);

        // Bounce for 40 cycles, then stable
        n_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            keys[2*4+1] = ~keys[2*4+1];
            run(5);
        end
        check("bounce_no_strobe", n_pulses, 0);
        keys[2*4+1] = 1'b1;
        wait_valid(80, "bounce_strobe_timeout");
        run(10);
        check("bounce_one_strobe", n_pulses, 1);

        // Two-tick release glitch while held
        n_pulses = 0;
        dropped  = 0;
        keys = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (kif.key_pressed !== 1'b1) dropped = 1;
        end
        keys[2*4+1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (kif.key_pressed !== 1'b1) dropped = 1;
        end
        check("glitch_pressed_kept", dropped, 0);
        check("glitch_no_strobe", n_pulses, 0);
        keys = '0;
        wait_released(40, "glitch_release_timeout");

        // Rows 0 and 3 on column 2, then a second key elsewhere
        n_pulses = 0;
        keys[0*4+2] = 1'b1;
        keys[3*4+2] = 1'b1;
        wait_valid(60, "multi_strobe_timeout");
        check("multi_row_priority", kif.key_code, 4'b0010);
        keys[1*4+0] = 1'b1;
        run(40);
        check("rollover_code", kif.key_code, 4'b0010);
        if (!TYPEMATIC) check("rollover_single_pulse", n_pulses, 1);
        keys = '0;
        wait_released(40, "multi_release_timeout");

        // Randomized presses and releases
        for (int i = 0; i < 14; i++) begin
            k = $urandom_range(0, 15);
            keys[k] = 1'b1;
            if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
            run($urandom_range(10, 70));
            keys = '0;
            run($urandom_range(5, 40));
        end
        keys = '0;
        run(40);

        // Hold key F: auto-repeat in the typematic build, silence otherwise
        keys[15] = 1'b1;
        wait_valid(60, "keyf_strobe_timeout");
        check("keyf_code", kif.key_code, 4'hF);
        n_pulses = 0;
        run(4 * REP * 3);
        check("keyf_repeats", n_pulses, TYPEMATIC ? 3 : 0);

        // Reset mid-hold
        rst_n = 1'b0;
        step();
        check("midrst_col_out", kif.col_out, 4'b0111);
        check("midrst_key_valid", kif.key_valid, 0);
        check("midrst_key_pressed", kif.key_pressed, 0);
        check("midrst_key_code", kif.key_code, 4'h0);
        keys = '0;
        run(2);
        rst_n = 1'b1;
        run(20);

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
